// File: rtl/umi_arb_pkg.sv
// umi_arb_pkg: shared helpers for the UMI request arbiter
// and its sibling TX-side schedulers.
`define UMI_FLD(bus, i, w) \
    bus[umi_arb_pkg::fld_off(int'(i), (w)) +: (w)]
`define UMI_BEAT_T(cw, aw, dw) \
    struct packed { \
        logic [(cw)-1:0] cmd; \
        logic [(aw)-1:0] dstaddr; \
        logic [(aw)-1:0] srcaddr; \
        logic [(dw)-1:0] data; \
    }

package umi_arb_pkg;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int fld_off(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/umi_rr_pick.sv
// umi_rr_pick: rotating priority encoder with optional
// owner hold, purely combinational.
module umi_rr_pick
    import umi_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int SW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          hold,
    output logic [SW-1:0] sel,
    output logic          any
);

    function automatic logic [SW-1:0] wrap(input int v);
        return (v >= N) ? SW'(v - N) : SW'(v);
    endfunction

    logic found;

    always_comb begin
        sel   = ptr;
        any   = |req;
        found = hold && req[ptr];
        // scan ptr+1 .. ptr+N, so ptr itself is checked last
        for (int k = 1; k <= N; k++) begin
            if (!found && req[wrap(int'(ptr) + k)]) begin
                sel   = wrap(int'(ptr) + k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/umi_rr_arbiter.sv
// umi_rr_arbiter: N-to-1 UMI request arbiter, round-robin
// with a burst allowance and a fully registered output.
module umi_rr_arbiter
    import umi_arb_pkg::*;
#(
    parameter int N         = 2,
    parameter int DW        = 256,
    parameter int AW        = 64,
    parameter int CW        = 32,
    parameter int MAX_BURST = 4,
    localparam int SW       = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [N*CW-1:0] in_cmd,
    input  logic [N*AW-1:0] in_dstaddr,
    input  logic [N*AW-1:0] in_srcaddr,
    input  logic [N*DW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_cmd,
    output logic [AW-1:0]   out_dstaddr,
    output logic [AW-1:0]   out_srcaddr,
    output logic [DW-1:0]   out_data,
    output logic [SW-1:0]   out_src
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX    = BW'(MAX_BURST);
    localparam logic [SW-1:0] OWN_RST = SW'(N - 1);

    typedef `UMI_BEAT_T(CW, AW, DW) beat_t;

    logic [SW-1:0] owner;
    logic [SW-1:0] sel;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_nxt;
    logic          load_en;
    logic          any;
    logic          hold;
    logic          xfer;
    beat_t         beat_d;
    beat_t         beat_q;

    assign load_en = !out_valid || out_ready;

    // burst_cnt==0 only after reset: nobody owns the
    // stream yet, so the scan from owner+1 starts at port 0
    assign hold = (burst_cnt != '0) && (burst_cnt < BMAX);

    umi_rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req  (in_valid),
        .ptr  (owner),
        .hold (hold),
        .sel  (sel),
        .any  (any)
    );

    assign xfer = load_en && any;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        beat_d         = '0;
        beat_d.cmd     = `UMI_FLD(in_cmd, sel, CW);
        beat_d.dstaddr = `UMI_FLD(in_dstaddr, sel, AW);
        beat_d.srcaddr = `UMI_FLD(in_srcaddr, sel, AW);
        beat_d.data    = `UMI_FLD(in_data, sel, DW);
    end

    always_comb begin
        burst_nxt = BW'(1);
        if (sel == owner) begin
            burst_nxt = (burst_cnt >= BMAX) ? BMAX
                                            : burst_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid <= 1'b0;
            beat_q    <= '0;
            out_src   <= '0;
            owner     <= OWN_RST;
            burst_cnt <= '0;
        end else if (load_en) begin
            out_valid <= any;
            if (any) begin
                beat_q    <= beat_d;
                out_src   <= sel;
                owner     <= sel;
                burst_cnt <= burst_nxt;
            end
        end
    end

    assign out_cmd     = beat_q.cmd;
    assign out_dstaddr = beat_q.dstaddr;
    assign out_srcaddr = beat_q.srcaddr;
    assign out_data    = beat_q.data;

endmodule

// File: tb/tb_umi_rr_arbiter.sv
// tb_umi_rr_arbiter: directed tests over three arbiter
// configurations sharing one clock and reset.
module tb_umi_rr_arbiter;

    logic clk;
    logic nreset;
    int   n_chk;
    int   n_fail;

    // A: N=3, MAX_BURST=1
    logic [2:0]  a_v, a_r;
    logic [23:0] a_cmd;
    logic [47:0] a_dst, a_src;
    logic [95:0] a_dat;
    logic        a_ov, a_ordy;
    logic [7:0]  a_oc;
    logic [15:0] a_od, a_os;
    logic [31:0] a_odat;
    logic [1:0]  a_sel;

    // B: N=2, MAX_BURST=4
    logic [1:0]  b_v, b_r;
    logic [15:0] b_cmd;
    logic [31:0] b_dst, b_src;
    logic [63:0] b_dat;
    logic        b_ov, b_ordy;
    logic [7:0]  b_oc;
    logic [15:0] b_od, b_os;
    logic [31:0] b_odat;
    logic [0:0]  b_sel;

    // C: N=3, MAX_BURST=4
    logic [2:0]  c_v, c_r;
    logic [23:0] c_cmd;
    logic [47:0] c_dst, c_src;
    logic [95:0] c_dat;
    logic        c_ov, c_ordy;
    logic [7:0]  c_oc;
    logic [15:0] c_od, c_os;
    logic [31:0] c_odat;
    logic [1:0]  c_sel;

    umi_rr_arbiter #(
        .N(3), .DW(32), .AW(16), .CW(8), .MAX_BURST(1)
    ) u_a (
        .clk(clk), .nreset(nreset),
        .in_valid(a_v), .in_ready(a_r),
        .in_cmd(a_cmd), .in_dstaddr(a_dst),
        .in_srcaddr(a_src), .in_data(a_dat),
        .out_valid(a_ov), .out_ready(a_ordy),
        .out_cmd(a_oc), .out_dstaddr(a_od),
        .out_srcaddr(a_os), .out_data(a_odat),
        .out_src(a_sel)
    );

    umi_rr_arbiter #(
        .N(2), .DW(32), .AW(16), .CW(8), .MAX_BURST(4)
    ) u_b (
        .clk(clk), .nreset(nreset),
        .in_valid(b_v), .in_ready(b_r),
        .in_cmd(b_cmd), .in_dstaddr(b_dst),
        .in_srcaddr(b_src), .in_data(b_dat),
        .out_valid(b_ov), .out_ready(b_ordy),
        .out_cmd(b_oc), .out_dstaddr(b_od),
        .out_srcaddr(b_os), .out_data(b_odat),
        .out_src(b_sel)
    );

    umi_rr_arbiter #(
        .N(3), .DW(32), .AW(16), .CW(8), .MAX_BURST(4)
    ) u_c (
        .clk(clk), .nreset(nreset),
        .in_valid(c_v), .in_ready(c_r),
        .in_cmd(c_cmd), .in_dstaddr(c_dst),
        .in_srcaddr(c_src), .in_data(c_dat),
        .out_valid(c_ov), .out_ready(c_ordy),
        .out_cmd(c_oc), .out_dstaddr(c_od),
        .out_srcaddr(c_os), .out_data(c_odat),
        .out_src(c_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        nreset = 1'b0;
        a_v = '0; a_cmd = '0; a_dst = '0;
        a_src = '0; a_dat = '0; a_ordy = 1'b1;
        b_v = '0; b_cmd = '0; b_dst = '0;
        b_src = '0; b_dat = '0; b_ordy = 1'b1;
        c_v = '0; c_cmd = '0; c_dst = '0;
        c_src = '0; c_dat = '0; c_ordy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 3) nreset = 1'b1;
            #1;
            n_chk++;
            if (a_ov !== 1'b0 || b_ov !== 1'b0 ||
                c_ov !== 1'b0 || a_sel !== 2'd0 ||
                b_sel !== 1'b0 || c_sel !== 2'd0 ||
                a_r !== 3'd0 || b_r !== 2'd0 ||
                c_r !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_idle k=%0d: ov=%b%b%b src=%0d/%0d/%0d rdy=%b/%b/%b want all 0",
                         k, a_ov, b_ov, c_ov, a_sel, b_sel,
                         c_sel, a_r, b_r, c_r);
            end
        end
    endtask

    task automatic test_round_robin();
        int cnt [3];
        int es, ed;
        cnt = '{0, 0, 0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k > 0) begin
                es = (k - 1) % 3;
                ed = es * 256 + (k - 1) / 3;
                n_chk++;
                if (a_ov !== 1'b1 || a_sel !== 2'(es) ||
                    a_odat !== 32'(ed)) begin
                    n_fail++;
                    $display("FAIL rr_out beat=%0d: ov=%b src=%0d data=%h want 1 %0d %h",
                             k - 1, a_ov, a_sel, a_odat, es, ed);
                end
            end
            if (k < 9) begin
                a_v = 3'b111;
                for (int i = 0; i < 3; i++)
                    a_dat[i*32 +: 32] = 32'(i * 256 + cnt[i]);
                #1;
                n_chk++;
                if (a_r !== 3'(1 << (k % 3))) begin
                    n_fail++;
                    $display("FAIL rr_ready k=%0d: got %b want %b",
                             k, a_r, 3'(1 << (k % 3)));
                end
                for (int i = 0; i < 3; i++)
                    if (a_r[i]) cnt[i]++;
            end else begin
                a_v = '0;
            end
        end
    endtask

    task automatic test_burst_cap();
        int e, pe;
        pe = 0;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_chk++;
                if (b_ov !== 1'b1 || b_sel !== 1'(pe) ||
                    b_oc !== 8'(16 + pe) ||
                    b_odat !== 32'(pe * 256 + k - 1)) begin
                    n_fail++;
                    $display("FAIL burst_out beat=%0d: ov=%b src=%0d cmd=%h data=%h want src %0d",
                             k - 1, b_ov, b_sel, b_oc, b_odat, pe);
                end
            end
            if (k < 16) begin
                e = (k < 10) ? (k / 4) % 2 : 0;
                b_v = (k < 10) ? 2'b11 : 2'b01;
                for (int i = 0; i < 2; i++) begin
                    b_dat[i*32 +: 32] = 32'(i * 256 + k);
                    b_cmd[i*8 +: 8] = 8'(16 + i);
                end
                #1;
                n_chk++;
                if (b_r !== 2'(1 << e)) begin
                    n_fail++;
                    $display("FAIL burst_ready k=%0d: got %b want %b",
                             k, b_r, 2'(1 << e));
                end
                pe = e;
            end else begin
                b_v = '0;
            end
        end
    endtask

    task automatic chk_c(input string nm,
                         input logic [15:0] d,
                         input logic [15:0] s,
                         input logic [2:0] r);
        #1;
        n_chk++;
        if (c_ov !== 1'b1 || c_od !== d || c_os !== s ||
            c_r !== r) begin
            n_fail++;
            $display("FAIL %s: ov=%b dst=%h src=%h rdy=%b want 1 %h %h %b",
                     nm, c_ov, c_od, c_os, c_r, d, s, r);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        c_ordy = 1'b1;
        c_v = 3'b010;
        c_dst[16 +: 16] = 16'h1000;
        c_src[16 +: 16] = 16'h0010;
        #1;
        n_chk++;
        if (c_r !== 3'b010) begin
            n_fail++;
            $display("FAIL bp_first_ready: got %b want 010", c_r);
        end
        @(negedge clk);
        c_ordy = 1'b0;
        c_dst[16 +: 16] = 16'h1001;
        c_src[16 +: 16] = 16'h0011;
        chk_c("bp_load", 16'h1000, 16'h0010, 3'b000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_c("bp_stall", 16'h1000, 16'h0010, 3'b000);
        end
        c_ordy = 1'b1;
        chk_c("bp_release", 16'h1000, 16'h0010, 3'b010);
        @(negedge clk);
        c_dst[16 +: 16] = 16'h1002;
        c_src[16 +: 16] = 16'h0012;
        chk_c("bp_next", 16'h1001, 16'h0011, 3'b010);
        @(negedge clk);
        c_v = '0;
        chk_c("bp_last", 16'h1002, 16'h0012, 3'b000);
        @(negedge clk);
        #1;
        n_chk++;
        if (c_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: ov=%b want 0", c_ov);
        end
    endtask

    task automatic test_wrap_drop();
        logic [2:0] vt [8];
        int         et [8];
        vt = '{3'b100, 3'b100, 3'b101, 3'b001,
               3'b101, 3'b101, 3'b101, 3'b101};
        et = '{2, 2, 2, 0, 0, 0, 0, 2};
        for (int i = 0; i < 3; i++) begin
            c_cmd[i*8 +: 8] = 8'(8'hC0 + i);
            c_dat[i*32 +: 32] = 32'(32'hC0 + i);
        end
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_chk++;
                if (c_ov !== 1'b1 || c_sel !== 2'(et[k-1])) begin
                    n_fail++;
                    $display("FAIL wrap_out k=%0d: ov=%b src=%0d want 1 %0d",
                             k - 1, c_ov, c_sel, et[k-1]);
                end
            end
            if (k < 8) begin
                c_v = vt[k];
                #1;
                n_chk++;
                if (c_r !== 3'(1 << et[k])) begin
                    n_fail++;
                    $display("FAIL wrap_ready k=%0d: got %b want %b",
                             k, c_r, 3'(1 << et[k]));
                end
            end else begin
                c_v = '0;
            end
        end
        n_chk++;
        if (c_oc !== 8'hC2 || c_odat !== 32'hC2) begin
            n_fail++;
            $display("FAIL wrap_fields: cmd=%h data=%h want c2 c2",
                     c_oc, c_odat);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a_ordy = 1'b1;
        a_v = 3'b010;
        a_dat[32 +: 32] = 32'hA5A5;
        a_cmd[8 +: 8] = 8'h5A;
        @(negedge clk);
        a_v = '0;
        a_ordy = 1'b0;
        #1;
        n_chk++;
        if (a_ov !== 1'b1 || a_sel !== 2'd1 ||
            a_odat !== 32'hA5A5) begin
            n_fail++;
            $display("FAIL ar_pending: ov=%b src=%0d data=%h want 1 1 a5a5",
                     a_ov, a_sel, a_odat);
        end
        #1 nreset = 1'b0;
        #1;
        n_chk++;
        if (a_ov !== 1'b0 || a_sel !== 2'd0 ||
            a_odat !== 32'd0 || a_oc !== 8'd0 ||
            a_od !== 16'd0 || a_os !== 16'd0) begin
            n_fail++;
            $display("FAIL ar_async: ov=%b src=%0d data=%h cmd=%h want 0 0 0 0",
                     a_ov, a_sel, a_odat, a_oc);
        end
        @(negedge clk);
        a_v = 3'b111;
        a_ordy = 1'b1;
        @(negedge clk);
        nreset = 1'b1;
        #1;
        n_chk++;
        if (a_r !== 3'b001) begin
            n_fail++;
            $display("FAIL ar_first_ready: got %b want 001", a_r);
        end
        @(negedge clk);
        a_v = '0;
        #1;
        n_chk++;
        if (a_ov !== 1'b1 || a_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL ar_first_grant: ov=%b src=%0d want 1 0",
                     a_ov, a_sel);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_wrap_drop();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/umi_rr_arbiter.md
Name: umi_rr_arbiter

Overview:
- Shares one UMI request stream (cmd/dstaddr/srcaddr/data with valid/ready) between N UMI requesters.
- Arbitration is round-robin with a bounded burst allowance.
- Output is fully registered, so it drives a UMI RX/TX queue endpoint or downstream fabric directly.
- Each UMI transaction is a single beat; arbitration is per beat.

Parameters:
- N, 2, number of requesters (N >= 2)
- DW, 256, UMI data width
- AW, 64, UMI address width (srcaddr and dstaddr)
- CW, 32, UMI command width
- MAX_BURST, 4, max consecutive grants to one requester while others wait (>= 1; 1 = pure round-robin)

Ports:
- clk  input  1  sole clock
- nreset  input  1  asynchronous active-low reset
- in_valid  input  N  per-requester valid
- in_ready  output  N  per-requester ready
- in_cmd  input  N*CW  flattened; requester i at [i*CW +: CW]
- in_dstaddr  input  N*AW  flattened, same indexing
- in_srcaddr  input  N*AW  flattened, same indexing
- in_data  input  N*DW  flattened, same indexing
- out_valid  output  1  registered valid
- out_ready  input  1  downstream ready
- out_cmd  output  CW  registered
- out_dstaddr  output  AW  registered
- out_srcaddr  output  AW  registered
- out_data  output  DW  registered
- out_src  output  SW=$clog2(N)  index of requester that supplied the current out beat

Behaviour:
- Reset (nreset low, async): out_valid=0; out_cmd/dstaddr/srcaddr/data=0; out_src=0; owner=N-1 (port 0 has first priority); burst_cnt=0. No transfer is in flight after reset release.
- load_en = !out_valid || out_ready. Output register loads only when load_en is set.
- Selection (combinational, each cycle):
  - Owner keeps priority when in_valid[owner] and burst_cnt < MAX_BURST.
  - Otherwise sel = first i with in_valid[i], scanning owner+1, owner+2, ... mod N, ending at owner.
  - any = |in_valid.
- in_ready[i] = load_en && any && (sel == i). At most one bit is set. in_ready may depend on in_valid of other ports; consumers must not make in_valid depend on in_ready.
- Transfer on port i = in_valid[i] && in_ready[i]. On a transfer, next cycle:
  - out_valid=1, out_*=port i fields, out_src=i, owner=i.
  - burst_cnt = (i==owner) ? min(burst_cnt+1, MAX_BURST) : 1.
- load_en with no input valid: out_valid<=0; out fields hold their last values (don't-care). Owner and burst_cnt hold.
- out_valid && !out_ready: all out_* hold stable, all in_ready=0, owner and burst_cnt hold.
- Throughput: one beat per cycle when out_ready stays high. Latency is 1 cycle from input transfer to out_valid.
- Fairness: a requester that holds valid waits at most (N-1)*MAX_BURST accepted beats before its grant.
- Wrap-around: the scan index wraps modulo N; owner=N-1 scans 0 first.
- A requester dropping valid mid-burst loses ownership priority immediately; its burst_cnt is not retained.
- Reset mid-operation: the pending out beat is discarded (out_valid=0 at once). Upstream senders must re-present data. No partial state survives.
- No combinational path from out_ready to out_*; out_ready reaches in_ready combinationally via load_en.

Decomposition:
- Shared package umi_arb_pkg: function clog2_min1 (SW for N), localparam helpers for field offsets, and a UMI beat struct {cmd, dstaddr, srcaddr, data} parameterised through macros for the flattened pack/unpack.
- Sub-module umi_rr_pick: purely combinational rotating priority encoder.
  - Inputs: req[N], ptr[SW], hold (owner-priority qualifier).
  - Outputs: sel[SW], any.
  - Reusable by the sibling TX-side demux scheduler.
- Top holds the output register, owner and burst counter.

Test Plan:
- Reset then idle: nreset low 3 cycles, all in_valid=0 → out_valid=0, out_src=0, in_ready=0 throughout.
- Pure round-robin: N=3, MAX_BURST=1, all valid continuously, out_ready=1 → out_src sequence 0,1,2,0,1,2; one beat per cycle; data matches per-port counters.
- Burst cap: N=2, MAX_BURST=4, both valid, out_ready=1 → out_src 0,0,0,0,1,1,1,1,0...; port 0 alone valid → out_src=0 every cycle (no starvation cap when uncontended).
- Backpressure: out_valid=1 with out_dstaddr=0x1000; out_ready=0 for 5 cycles → out_* stable, in_ready=0; on out_ready=1 the next beat loads the following cycle with no loss or duplication (scoreboard by srcaddr).
- Wrap and drop: owner=N-1=2, only ports 0 and 2 valid, port 2 drops valid mid-burst → next grant port 0, burst_cnt=1.
- Async reset mid-stream: assert nreset low while out_valid=1 and out_ready=0 → out_valid=0 within the same cycle (before the next clk edge); after release first grant goes to port 0.
